// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timers: round states and LFSR tap masks.
package reaction_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GO   = 2'd2,
    DONE = 2'd3
  } rstate_t;

  localparam int unsigned LFSR_SEED = 1;

  // Galois right-shift feedback masks for maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       lfsr_taps = 32'h0000_00B8;
      16:      lfsr_taps = 32'h0000_B400;
      24:      lfsr_taps = 32'h00E1_0000;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running one-clock tick enable at TICK_HZ derived from CLK_HZ; no derived clocks.
module tick_gen #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned DIV   = (CLK_HZ / TICK_HZ > 1) ? CLK_HZ / TICK_HZ : 1;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/reaction_multi.sv
// N-player reaction timer: random go delay, per-player first-press timestamps in ticks,
// false-start detection and a session-best time with its holder.
module reaction_multi
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned N_PLAYERS = 4,
  parameter int unsigned TIME_W    = 11,
  parameter int unsigned MIN_DELAY = 1000,
  parameter int unsigned RAND_BITS = 10,
  parameter int unsigned LFSR_W    = 16,
  localparam int unsigned ID_W     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [N_PLAYERS-1:0]          i_btn,
  output logic                          o_go,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [N_PLAYERS*TIME_W-1:0]   o_react_time,
  output logic [N_PLAYERS-1:0]          o_valid,
  output logic [N_PLAYERS-1:0]          o_false_start,
  output logic [TIME_W-1:0]             o_best_time,
  output logic [ID_W-1:0]               o_best_id
);

  localparam logic [TIME_W-1:0] T_MAX  = '1;
  localparam int unsigned       DLY_W  = $clog2(MIN_DELAY + 2 ** RAND_BITS);
  localparam logic [31:0]       TAPS32 = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS   = TAPS32[LFSR_W-1:0];

  rstate_t                         r_state;
  logic [LFSR_W-1:0]               r_lfsr;
  logic                            r_start_q;
  logic [N_PLAYERS-1:0]            r_btn_q;
  logic [DLY_W-1:0]                r_dly;
  logic [TIME_W-1:0]               r_ms;
  logic [N_PLAYERS-1:0][TIME_W-1:0] r_rt;
  logic [N_PLAYERS-1:0]            r_valid;
  logic [N_PLAYERS-1:0]            r_fs;
  logic                            r_done;
  logic [TIME_W-1:0]               r_best;
  logic [ID_W-1:0]                 r_best_id;

  logic                 w_tick;
  logic [LFSR_W-1:0]    w_lfsr_step;
  logic                 w_start_edge;
  logic [N_PLAYERS-1:0] w_btn_edge, w_cap, w_fs_nx, w_valid_nx;
  logic                 w_all_res, w_timeout, w_go_exit, w_any;
  logic [TIME_W-1:0]    w_min;
  logic [ID_W-1:0]      w_min_id;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (w_tick)
  );

  assign w_lfsr_step  = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
  assign w_start_edge = i_start & ~r_start_q;
  assign w_btn_edge   = i_btn & ~r_btn_q;
  assign w_cap        = (r_state == GO)  ? (w_btn_edge & ~r_valid & ~r_fs) : '0;
  assign w_fs_nx      = (r_state == ARM) ? (r_fs | w_btn_edge) : r_fs;
  assign w_valid_nx   = r_valid | w_cap;
  assign w_all_res    = &(w_valid_nx | w_fs_nx);
  assign w_timeout    = (r_ms == T_MAX);
  assign w_go_exit    = (r_state == GO) && (w_all_res || w_timeout);

  // Fastest legal time including this cycle's captures; strict < keeps the lowest index on ties.
  always_comb begin
    w_min    = T_MAX;
    w_min_id = '0;
    w_any    = 1'b0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (w_valid_nx[i] && (!w_any || (w_cap[i] ? r_ms : r_rt[i]) < w_min)) begin
        w_min    = w_cap[i] ? r_ms : r_rt[i];
        w_min_id = ID_W'(i);
        w_any    = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_lfsr    <= LFSR_W'(LFSR_SEED);
      r_start_q <= 1'b1;
      r_btn_q   <= '1;
      r_dly     <= '0;
      r_ms      <= '0;
      r_rt      <= '0;
      r_valid   <= '0;
      r_fs      <= '0;
      r_done    <= 1'b0;
      r_best    <= T_MAX;
      r_best_id <= '0;
    end else begin
      r_start_q <= i_start;
      r_btn_q   <= i_btn;
      r_lfsr    <= (w_lfsr_step == '0) ? LFSR_W'(LFSR_SEED) : w_lfsr_step;
      r_done    <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_start_edge) begin
            r_valid <= '0;
            r_fs    <= '0;
            r_rt    <= '0;
            r_dly   <= DLY_W'(MIN_DELAY) + DLY_W'(r_lfsr[RAND_BITS-1:0]);
            r_state <= ARM;
          end
        end
        ARM: begin
          r_fs <= w_fs_nx;
          if (&w_fs_nx) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_tick) begin
            if (r_dly == '0) begin
              r_state <= GO;
              r_ms    <= '0;
            end else begin
              r_dly <= r_dly - DLY_W'(1);
            end
          end
        end
        GO: begin
          r_valid <= w_valid_nx;
          for (int i = 0; i < N_PLAYERS; i++) begin
            if (w_cap[i]) begin
              r_rt[i] <= r_ms;
            end else if (w_timeout && !r_valid[i] && !r_fs[i]) begin
              r_rt[i] <= T_MAX;
            end
          end
          if (w_tick && !w_timeout) begin
            r_ms <= r_ms + TIME_W'(1);
          end
          if (w_go_exit) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            if (w_any && (w_min < r_best)) begin
              r_best    <= w_min;
              r_best_id <= w_min_id;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_go          = (r_state == GO);
  assign o_busy        = (r_state == ARM) || (r_state == GO);
  assign o_done        = r_done;
  assign o_react_time  = r_rt;
  assign o_valid       = r_valid;
  assign o_false_start = r_fs;
  assign o_best_time   = r_best;
  assign o_best_id     = r_best_id;

endmodule

// File: tb/tb_reaction_multi.sv
// Directed bench for reaction_multi: table of whole-round vectors plus hand-written corner cases.
module tb_reaction_multi;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [3:0]  i_btn;
  logic        o_go, o_busy, o_done;
  logic [43:0] o_react_time;
  logic [3:0]  o_valid, o_false_start;
  logic [10:0] o_best_time;
  logic [1:0]  o_best_id;

  int n_checks = 0;
  int n_err    = 0;
  bit lfsr_zero = 1'b0;

  reaction_multi #(
    .CLK_HZ    (1000),
    .TICK_HZ   (1000),
    .N_PLAYERS (4),
    .TIME_W    (11),
    .MIN_DELAY (1000),
    .RAND_BITS (10),
    .LFSR_W    (16)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_btn         (i_btn),
    .o_go          (o_go),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_react_time  (o_react_time),
    .o_valid       (o_valid),
    .o_false_start (o_false_start),
    .o_best_time   (o_best_time),
    .o_best_id     (o_best_id)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (i_rst_n && dut.r_lfsr == 16'h0000) lfsr_zero = 1'b1;
  end

  typedef struct packed {
    logic [3:0]       arm;        // players pressing in the first ARM clock
    logic [3:0]       go_mask;    // players pressing during GO
    logic [3:0][10:0] press_ms;   // GO press time per player (p3..p0)
    logic [3:0]       exp_valid;
    logic [3:0]       exp_fs;
    logic [3:0][10:0] exp_rt;
    logic [10:0]      exp_best;
    logic [1:0]       exp_id;
    logic             exp_go;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t       v;
    bit         go_seen;
    logic [3:0] m;
    int         k;
    v = vecs[idx];
    go_seen = 1'b0;
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) begin i_start = 1'b0; i_btn = v.arm; end
    @(negedge i_clk) i_btn = 4'b0000;
    for (int t = 0; t < 3000 && !o_go && !o_done; t++) @(negedge i_clk);
    if (o_go) begin
      go_seen = 1'b1;
      k = 0;
      while (!o_done && k < 2200) begin
        m = 4'b0000;
        for (int i = 0; i < 4; i++)
          if (v.go_mask[i] && int'(v.press_ms[i]) == k) m[i] = 1'b1;
        i_btn = m;
        @(negedge i_clk);
        k++;
      end
      i_btn = 4'b0000;
    end
    chk($sformatf("v%0d done_seen", idx), 32'(o_done), 32'd1);
    chk($sformatf("v%0d go_seen", idx), 32'(go_seen), 32'(v.exp_go));
    @(negedge i_clk);
    chk($sformatf("v%0d done_width", idx), 32'(o_done), 32'd0);
    chk($sformatf("v%0d busy", idx), 32'(o_busy), 32'd0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("v%0d rt%0d", idx, i), 32'(o_react_time[i*11 +: 11]), 32'(v.exp_rt[i]));
    chk($sformatf("v%0d valid", idx), 32'(o_valid), 32'(v.exp_valid));
    chk($sformatf("v%0d false_start", idx), 32'(o_false_start), 32'(v.exp_fs));
    chk($sformatf("v%0d best_time", idx), 32'(o_best_time), 32'(v.exp_best));
    chk($sformatf("v%0d best_id", idx), 32'(o_best_id), 32'(v.exp_id));
  endtask

  initial begin
    int n;
    // Player 2 at 250, others time out
    vecs[0] = '{arm: 4'b0000, go_mask: 4'b0100, press_ms: {11'd0, 11'd250, 11'd0, 11'd0},
                exp_valid: 4'b0100, exp_fs: 4'b0000,
                exp_rt: {11'd2047, 11'd250, 11'd2047, 11'd2047},
                exp_best: 11'd250, exp_id: 2'd2, exp_go: 1'b1};
    // Player 0 false-starts and presses again at 20; others answer
    vecs[1] = '{arm: 4'b0001, go_mask: 4'b1111, press_ms: {11'd500, 11'd400, 11'd300, 11'd20},
                exp_valid: 4'b1110, exp_fs: 4'b0001,
                exp_rt: {11'd500, 11'd400, 11'd300, 11'd0},
                exp_best: 11'd250, exp_id: 2'd2, exp_go: 1'b1};
    // Players 1 and 3 tie at 180
    vecs[2] = '{arm: 4'b0000, go_mask: 4'b1111, press_ms: {11'd180, 11'd190, 11'd180, 11'd600},
                exp_valid: 4'b1111, exp_fs: 4'b0000,
                exp_rt: {11'd180, 11'd190, 11'd180, 11'd600},
                exp_best: 11'd180, exp_id: 2'd1, exp_go: 1'b1};
    // No presses: full timeout
    vecs[3] = '{arm: 4'b0000, go_mask: 4'b0000, press_ms: '0,
                exp_valid: 4'b0000, exp_fs: 4'b0000,
                exp_rt: {11'd2047, 11'd2047, 11'd2047, 11'd2047},
                exp_best: 11'd180, exp_id: 2'd1, exp_go: 1'b1};
    // Everyone false-starts: no GO phase
    vecs[4] = '{arm: 4'b1111, go_mask: 4'b0000, press_ms: '0,
                exp_valid: 4'b0000, exp_fs: 4'b1111, exp_rt: '0,
                exp_best: 11'd180, exp_id: 2'd1, exp_go: 1'b0};
    // Mixed: 1 and 3 false-start, 0 and 2 tie at 3 -> new best held by 0
    vecs[5] = '{arm: 4'b1010, go_mask: 4'b0101, press_ms: {11'd0, 11'd3, 11'd0, 11'd3},
                exp_valid: 4'b0101, exp_fs: 4'b1010,
                exp_rt: {11'd0, 11'd3, 11'd0, 11'd3},
                exp_best: 11'd3, exp_id: 2'd0, exp_go: 1'b1};

    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_btn   = 4'b0000;
    repeat (3) @(negedge i_clk);
    chk("reset go", 32'(o_go), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset done", 32'(o_done), 32'd0);
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset false_start", 32'(o_false_start), 32'd0);
    chk("reset react_time", 32'(o_react_time == 44'd0), 32'd1);
    chk("reset best_time", 32'(o_best_time), 32'd2047);
    chk("reset best_id", 32'(o_best_id), 32'd0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    for (int v = 0; v < 6; v++) run_vec(v);

    // Reset in the middle of GO
    @(negedge i_clk) i_start = 1'b1;
    @(negedge i_clk) i_start = 1'b0;
    chk("arm busy", 32'(o_busy), 32'd1);
    chk("arm go", 32'(o_go), 32'd0);
    for (int t = 0; t < 3000 && !o_go; t++) @(negedge i_clk);
    chk("rst go_reached", 32'(o_go), 32'd1);
    repeat (10) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("rst go_async", 32'(o_go), 32'd0);
    chk("rst busy", 32'(o_busy), 32'd0);
    chk("rst best_time", 32'(o_best_time), 32'd2047);
    chk("rst best_id", 32'(o_best_id), 32'd0);
    // Inputs held high across reset release must not act as edges
    i_start = 1'b1;
    i_btn   = 4'b1111;
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (5) @(negedge i_clk);
    chk("held start no round", 32'(o_busy), 32'd0);
    chk("held btn no fs", 32'(o_false_start), 32'd0);
    i_start = 1'b0;
    i_btn   = 4'b0000;
    repeat (2) @(negedge i_clk);

    // Go rises dly+1 clocks after the start edge is sampled
    for (int r = 0; r < 5; r++) begin
      @(negedge i_clk) i_start = 1'b1;
      @(negedge i_clk) i_start = 1'b0;
      n = 0;
      while (!o_go && n < 3000) begin
        @(negedge i_clk);
        n++;
      end
      chk($sformatf("round%0d delay_in_range", r), 32'(n >= 1001 && n <= 2024), 32'd1);
      i_btn = 4'b1111;
      @(negedge i_clk) i_btn = 4'b0000;
      for (int t = 0; t < 10 && !o_done; t++) @(negedge i_clk);
      chk($sformatf("round%0d all_answered_done", r), 32'(o_done), 32'd1);
      repeat (3 + r) @(negedge i_clk);
    end

    // Loaded delay over many quick rounds, each ended by a full false start
    for (int r = 0; r < 100; r++) begin
      @(negedge i_clk) i_start = 1'b1;
      @(negedge i_clk) begin i_start = 1'b0; i_btn = 4'b1111; end
      chk($sformatf("quick%0d dly_range", r),
          32'(dut.r_dly >= 11'd1000 && dut.r_dly <= 11'd2023), 32'd1);
      @(negedge i_clk) i_btn = 4'b0000;
      repeat (1 + (r % 3)) @(negedge i_clk);
    end

    chk("lfsr never zero", 32'(lfsr_zero), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
